// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and the stages that consume its result
// stream.
//   alu_result_t : one ALU result as it appears on the wire, {cout, z[7:0]}.
//   ALU_RES_W    : width of alu_result_t.
//   sat_res_t    : return type of sat_add, {ovf, sum}.
//   sat_add      : saturating add of a result onto an accumulator of
//                  run-time-selected width (1..32 bits).
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_RES_W = 9;

    typedef struct packed {
        logic       cout;
        logic [7:0] z;
    } alu_result_t;

    typedef struct packed {
        logic        ovf;
        logic [31:0] sum;
    } sat_res_t;

    // The accumulator is passed zero-extended to 32 bits. It must already lie
    // within the range of a width-bit value, so any sum above that range is an
    // overflow and clamps to all-ones. The add is done in 33 bits so that a
    // 32-bit accumulator cannot wrap.
    function automatic sat_res_t sat_add(input logic [31:0]          acc,
                                         input logic [ALU_RES_W-1:0] val,
                                         input int unsigned          width);
        logic [32:0] total;
        logic [32:0] max_val;
        sat_res_t    res;
        total   = {1'b0, acc} + 33'(val);
        max_val = (33'd1 << width) - 33'd1;
        if (total > max_val) begin
            res.ovf = 1'b1;
            res.sum = max_val[31:0];
        end else begin
            res.ovf = 1'b0;
            res.sum = total[31:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_out_reg.sv
// -----------------------------------------------------------------------------
// alu_out_reg
// One-entry push/stop output register. A loaded word is presented with valid=1
// and is held stable until the consumer takes it, which happens on a rising
// edge with valid=1 and stopin=0.
//
// The producer must load only when the register is empty or is draining on
// the same edge. If load and drain coincide, the new word wins.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset; clears valid and data
//   load      in   capture load_data on this edge
//   load_data in   W  word to capture
//   stopin    in   consumer backpressure
//   valid     out  word present (drives the consumer's push)
//   data      out  W  held word
// -----------------------------------------------------------------------------
module alu_out_reg #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         stopin,
    output logic         valid,
    output logic [W-1:0] data
);

    logic drain;

    assign drain = valid & ~stopin;

    // NOTE: state is updated with non-blocking assignments so that every
    // register samples values from before the edge, whatever order the
    // simulator evaluates the always blocks in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_result_acc.sv
// -----------------------------------------------------------------------------
// alu_result_acc
// Sums each group of GROUP ALU results ({cout, z} as a 9-bit value) into one
// saturating SUM_W-bit sum. The sum is presented over push/stop through a
// one-entry output register, so the next group can accumulate while the
// previous sum waits.
//
// Parameters:
//   GROUP  results per group (2..255)
//   SUM_W  sum width (10..32)
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   pushin   in   upstream result valid
//   cout_in  in   result carry
//   z_in     in   8  result value
//   stopout  out  backpressure to upstream
//   pushout  out  sum valid to the consumer
//   sum      out  SUM_W  group sum
//   ovf      out  the group saturated
//   stopin   in   consumer backpressure
// -----------------------------------------------------------------------------
module alu_result_acc
    import alu_pkg::*;
#(
    parameter int GROUP = 4,
    parameter int SUM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pushin,
    input  logic             cout_in,
    input  logic [7:0]       z_in,
    output logic             stopout,
    output logic             pushout,
    output logic [SUM_W-1:0] sum,
    output logic             ovf,
    input  logic             stopin
);

    localparam int              CNT_W = $clog2(GROUP);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(GROUP - 1);

    logic [SUM_W-1:0] acc;
    logic             acc_ovf;
    logic [CNT_W-1:0] cnt;

    alu_result_t      in_res;
    sat_res_t         add_res;
    logic [SUM_W-1:0] add_sum;
    logic             accept;
    logic             last;
    logic             out_valid;
    logic [SUM_W:0]   out_data;

    // Bits of the 32-bit helper result above SUM_W are always zero here; the
    // reduction only marks them as consumed.
    logic             unused_add_bits;

    assign in_res          = '{cout: cout_in, z: z_in};
    assign add_res         = sat_add(32'(acc), in_res, SUM_W);
    assign add_sum         = add_res.sum[SUM_W-1:0];
    assign unused_add_bits = ^add_res.sum;

    assign last   = (cnt == LAST);
    assign accept = pushin & ~stopout;

    // Only the final input of a group needs room in the output register, so
    // only it is held off. The decision uses registered state only; it stays
    // asserted through the drain edge and releases one cycle later.
    assign stopout = out_valid & last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            if (last) begin
                acc     <= '0;
                acc_ovf <= 1'b0;
                cnt     <= '0;
            end else begin
                acc     <= add_sum;
                acc_ovf <= acc_ovf | add_res.ovf;
                cnt     <= cnt + CNT_W'(1);
            end
        end
    end

    alu_out_reg #(
        .W(SUM_W + 1)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (accept & last),
        .load_data ({acc_ovf | add_res.ovf, add_sum}),
        .stopin    (stopin),
        .valid     (out_valid),
        .data      (out_data)
    );

    assign pushout = out_valid;
    assign sum     = out_data[SUM_W-1:0];
    assign ovf     = out_data[SUM_W];

endmodule

// File: tb/tb_alu_result_acc.sv
module tb_alu_result_acc;

    localparam int SUM_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // DUT A: GROUP=4
    logic             a_pushin, a_cout, a_stopin;
    logic [7:0]       a_z;
    logic             a_stopout, a_pushout, a_ovf;
    logic [SUM_W-1:0] a_sum;

    // DUT B: GROUP=200
    logic             b_pushin, b_cout, b_stopin;
    logic [7:0]       b_z;
    logic             b_stopout, b_pushout, b_ovf;
    logic [SUM_W-1:0] b_sum;

    alu_result_acc #(.GROUP(4), .SUM_W(SUM_W)) dut_a (
        .clk(clk), .rst(rst), .pushin(a_pushin), .cout_in(a_cout), .z_in(a_z),
        .stopout(a_stopout), .pushout(a_pushout), .sum(a_sum), .ovf(a_ovf),
        .stopin(a_stopin)
    );

    alu_result_acc #(.GROUP(200), .SUM_W(SUM_W)) dut_b (
        .clk(clk), .rst(rst), .pushin(b_pushin), .cout_in(b_cout), .z_in(b_z),
        .stopout(b_stopout), .pushout(b_pushout), .sum(b_sum), .ovf(b_ovf),
        .stopin(b_stopin)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        pushin;
        logic        cout;
        logic [7:0]  z;
        logic        stopin;
        logic        exp_stopout;
        logic        exp_pushout;
        logic        chk_sum;
        logic [15:0] exp_sum;
        logic        exp_ovf;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic pi, input logic c, input logic [7:0] z, input logic si,
                       input logic so, input logic po, input logic chk,
                       input logic [15:0] s, input logic o);
        vec_t v;
        v.pushin = pi; v.cout = c; v.z = z; v.stopin = si;
        v.exp_stopout = so; v.exp_pushout = po; v.chk_sum = chk;
        v.exp_sum = s; v.exp_ovf = o;
        vq.push_back(v);
    endtask

    // Apply one input cycle to DUT A and look at the outputs just after the edge.
    task automatic cyc_a(input logic pi, input logic c, input logic [7:0] z, input logic si);
        a_pushin = pi; a_cout = c; a_z = z; a_stopin = si;
        @(posedge clk); #1;
    endtask

    task automatic cyc_b(input logic pi, input logic c, input logic [7:0] z);
        b_pushin = pi; b_cout = c; b_z = z;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        a_pushin = 0; a_cout = 0; a_z = '0; a_stopin = 0;
        b_pushin = 0; b_cout = 0; b_z = '0; b_stopin = 0;

        // ---- vector table: DUT A, GROUP=4 ----
        // group 0x10+0x20+0x30+0x40 = 0xA0
        add(1,0,8'h10,0, 0,0,0,16'h0000,0);
        add(1,0,8'h20,0, 0,0,0,16'h0000,0);
        add(1,0,8'h30,0, 0,0,0,16'h0000,0);
        add(1,0,8'h40,0, 0,1,1,16'h00A0,0);
        add(0,0,8'h00,0, 0,0,0,16'h0000,0);
        // 4 x 511 = 2044
        add(1,1,8'hFF,0, 0,0,0,16'h0000,0);
        add(1,1,8'hFF,0, 0,0,0,16'h0000,0);
        add(1,1,8'hFF,0, 0,0,0,16'h0000,0);
        add(1,1,8'hFF,0, 0,1,1,16'h07FC,0);
        // 8 x 1: two sums of 4, four cycles apart
        add(1,0,8'h01,0, 0,0,0,16'h0000,0);
        add(1,0,8'h01,0, 0,0,0,16'h0000,0);
        add(1,0,8'h01,0, 0,0,0,16'h0000,0);
        add(1,0,8'h01,0, 0,1,1,16'h0004,0);
        add(1,0,8'h01,0, 0,0,0,16'h0000,0);
        add(1,0,8'h01,0, 0,0,0,16'h0000,0);
        add(1,0,8'h01,0, 0,0,0,16'h0000,0);
        add(1,0,8'h01,0, 0,1,1,16'h0004,0);
        add(0,0,8'h00,0, 0,0,0,16'h0000,0);
        // backpressure: stopin=1, stream 8 x 1
        add(1,0,8'h01,1, 0,0,0,16'h0000,0);
        add(1,0,8'h01,1, 0,0,0,16'h0000,0);
        add(1,0,8'h01,1, 0,0,0,16'h0000,0);
        add(1,0,8'h01,1, 0,1,1,16'h0004,0);
        add(1,0,8'h01,1, 0,1,1,16'h0004,0);
        add(1,0,8'h01,1, 0,1,1,16'h0004,0);
        add(1,0,8'h01,1, 1,1,1,16'h0004,0);
        add(1,0,8'h01,1, 1,1,1,16'h0004,0);   // 8th input held
        add(1,0,8'h01,1, 1,1,1,16'h0004,0);
        add(1,0,8'h01,0, 0,0,0,16'h0000,0);   // release: drain, stopout falls
        add(1,0,8'h01,0, 0,1,1,16'h0004,0);   // held input accepted -> sum 4
        add(0,0,8'h00,0, 0,0,0,16'h0000,0);

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("reset pushout", 32'(a_pushout), 0);
        check("reset stopout", 32'(a_stopout), 0);
        check("reset sum", 32'(a_sum), 0);
        check("reset ovf", 32'(a_ovf), 0);
        check("reset b pushout", 32'(b_pushout), 0);
        rst = 1'b0;

        // ---- table-driven run ----
        for (int i = 0; i < vq.size(); i++) begin
            cyc_a(vq[i].pushin, vq[i].cout, vq[i].z, vq[i].stopin);
            check($sformatf("vec%0d pushout", i), 32'(a_pushout), 32'(vq[i].exp_pushout));
            check($sformatf("vec%0d stopout", i), 32'(a_stopout), 32'(vq[i].exp_stopout));
            if (vq[i].chk_sum) begin
                check($sformatf("vec%0d sum", i), 32'(a_sum), 32'(vq[i].exp_sum));
                check($sformatf("vec%0d ovf", i), 32'(a_ovf), 32'(vq[i].exp_ovf));
            end
        end

        // ---- reset mid-group ----
        cyc_a(1,0,8'h01,0);
        cyc_a(1,0,8'h01,0);
        a_pushin = 0;
        #3 rst = 1'b1;
        #1;
        check("rst mid-group pushout", 32'(a_pushout), 0);
        check("rst mid-group stopout", 32'(a_stopout), 0);
        check("rst mid-group sum", 32'(a_sum), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc_a(1,0,8'h01,0);
        cyc_a(1,0,8'h01,0);
        cyc_a(1,0,8'h01,0);
        check("post-rst1 early pushout", 32'(a_pushout), 0);
        cyc_a(1,0,8'h01,0);
        check("post-rst1 pushout", 32'(a_pushout), 1);
        check("post-rst1 sum", 32'(a_sum), 4);
        cyc_a(0,0,8'h00,0);

        // ---- reset with a sum pending under stopin=1 ----
        for (int i = 0; i < 7; i++) cyc_a(1,0,8'h01,1);
        check("pending pushout", 32'(a_pushout), 1);
        check("pending stopout", 32'(a_stopout), 1);
        #3 rst = 1'b1;
        #1;
        check("rst pending pushout", 32'(a_pushout), 0);
        check("rst pending stopout", 32'(a_stopout), 0);
        check("rst pending sum", 32'(a_sum), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc_a(1,0,8'h01,0);
        cyc_a(1,0,8'h01,0);
        cyc_a(1,0,8'h01,0);
        check("post-rst2 early pushout", 32'(a_pushout), 0);
        cyc_a(1,0,8'h01,0);
        check("post-rst2 pushout", 32'(a_pushout), 1);
        check("post-rst2 sum", 32'(a_sum), 4);
        cyc_a(0,0,8'h00,0);

        // ---- DUT B: GROUP=200 saturation, then a zero group ----
        for (int i = 0; i < 199; i++) cyc_b(1,1,8'hFF);
        check("g200 early pushout", 32'(b_pushout), 0);
        cyc_b(1,1,8'hFF);
        check("g200 sat pushout", 32'(b_pushout), 1);
        check("g200 sat sum", 32'(b_sum), 32'hFFFF);
        check("g200 sat ovf", 32'(b_ovf), 1);
        for (int i = 0; i < 199; i++) cyc_b(1,0,8'h00);
        check("g200 zero early pushout", 32'(b_pushout), 0);
        cyc_b(1,0,8'h00);
        check("g200 zero pushout", 32'(b_pushout), 1);
        check("g200 zero sum", 32'(b_sum), 0);
        check("g200 zero ovf", 32'(b_ovf), 0);
        cyc_b(0,0,8'h00);
        check("g200 drained", 32'(b_pushout), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_result_acc.md
# alu_result_acc

Downstream stage of the ALU that consumes its result stream (carry plus 8-bit result) over the push/stop handshake. It sums each fixed-size group of results into one saturating sum and presents that sum to the next consumer over the same push/stop handshake. A one-entry output register lets the next group accumulate while the previous sum waits for the consumer.

## Interface
Parameters:
- GROUP, 4: results per group; legal range 2..255.
- SUM_W, 16: sum width; legal range 10..32.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- pushin  input  1  upstream result valid; connects to ALU pushout.
- cout_in  input  1  result carry; connects to ALU cout.
- z_in  input  8  result value; connects to ALU z.
- stopout  output  1  backpressure to upstream; connects to ALU stopin.
- pushout  output  1  sum valid to the consumer.
- sum  output  SUM_W  group sum.
- ovf  output  1  the group saturated.
- stopin  input  1  consumer backpressure.

## Operation
- Input transfer happens on a rising edge with pushin=1 and stopout=0. Output transfer happens on a rising edge with pushout=1 and stopin=0.
- Operand value is {cout_in,z_in}, zero-extended to SUM_W+1 bits, range 0..511.
- State:
  - acc, SUM_W bits.
  - acc_ovf.
  - cnt, 0..GROUP-1, width clog2(GROUP).
  - Output register {out_valid, out_sum, out_ovf}.
- On a non-final accepted input (cnt<GROUP-1): acc += value, saturating at all-ones with acc_ovf set sticky. cnt increments.
- On the final accepted input (cnt==GROUP-1):
  - out_sum <= sat(acc+value).
  - out_ovf <= acc_ovf | the overflow produced by this final add.
  - out_valid <= 1.
  - acc, acc_ovf and cnt clear to 0.
- stopout = out_valid & (cnt==GROUP-1). It is purely registered state, with no combinational path from stopin.
  - Only the final input of a group is ever blocked.
  - It is blocked conservatively, even in the cycle in which the output is draining.
- Output drain: out_valid clears on an output transfer. If a final input is accepted on the same edge (possible only when out_valid was 0 before that edge), the new sum is loaded instead.
- Outputs: pushout=out_valid, sum=out_sum, ovf=out_ovf. All three are held stable while pushout=1 and stopin=1.
- Reset values: acc=0, acc_ovf=0, cnt=0, out_valid=0, out_sum=0, out_ovf=0. Therefore pushout=0, sum=0, ovf=0 and stopout=0 during and after reset.
- Reset mid-group discards the partial group. Reset with a pending sum discards the sum.
- No carry-in between groups: every group starts from 0.

## Timing
- Latency: if the final input of a group is accepted at edge k, pushout=1 is visible from edge k until it is drained.
- Throughput with stopin=0: one input per cycle sustained, one sum every GROUP cycles, no bubbles.
- With stopin held at 1 and a sum pending:
  - GROUP-1 further inputs are accepted.
  - stopout then rises after the edge that makes cnt==GROUP-1.
- When stopin falls, the drain edge clears out_valid. stopout falls after that edge, and the blocked input is accepted on the following edge.
- pushin is ignored while stopout=1; upstream holds its data.
- Input and output transfers on the same edge are both honoured.

## Structure
- Shared package alu_pkg holds:
  - typedef alu_result_t, a packed struct of {cout, z[7:0]}.
  - localparam ALU_RES_W=9.
  - A saturating-add function sat_add(acc, val, SUM_W) returning {ovf, sum}.
- One natural sub-module, alu_out_reg: the one-entry push/stop output register (valid/data/hold/drain logic). It is reusable by other stages.
- The accumulator, counter and stopout logic stay in alu_result_acc.

## Test plan
- GROUP=4, stopin=0: results 0x10, 0x20, 0x30, 0x40 with cout=0 on consecutive cycles. Required: pushout for one cycle, sum=0x00A0, ovf=0.
- GROUP=4: four results with cout=1, z=0xFF. Required: sum=0x07FC (2044), ovf=0. Then send 8 more results at value 1. Required: two sums of 0x0004, back to back, exactly 4 cycles apart.
- GROUP=200, SUM_W=16: 200 results all at value 511. Required: sum=0xFFFF, ovf=1. Then a group of 200 zeros. Required: sum=0, ovf=0 (the ovf flag does not carry across groups).
- Backpressure, GROUP=4, stopin=1:
  - Stimulus: stream 8 values of 1.
  - Required while stalled: the first sum (4) is held stable, 3 more inputs are accepted, then stopout=1 and the 8th input is held.
  - Required on release (stopin drops): the sum drains, stopout falls the next cycle, the 8th input is accepted, and the second sum of 4 appears.
- Reset mid-operation: assert rst asynchronously (between edges) after 2 of 4 inputs, and separately while a sum is pending with stopin=1. Required: pushout, stopout and sum drop to 0 immediately. After release, a fresh group of 4×0x01 yields sum=4.
